// File: rtl/sev_seg_scan.sv
// Multiplexed N-digit seven-segment driver: shadow register, refresh scan with
// ghost-guard blanking, BCD/hex decode, leading-zero suppression, decimal points.
module sev_seg_scan #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD_CYC   = 500
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    hex_mode,
    input  logic                    lz_suppress,
    input  logic                    blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [N_DIGITS-1:0]     dig_en,
    output logic                    frame_done
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [3:0]          sh_dig [N_DIGITS];
    logic [N_DIGITS-1:0] sh_dp;

    logic                cnt_last;
    logic                idx_last;
    logic                in_guard;
    logic [N_DIGITS-1:0] supp;
    logic                all_zero;

    logic [6:0]          seg_nxt;
    logic                dp_nxt;
    logic [N_DIGITS-1:0] dig_nxt;

    assign cnt_last = (cnt == CW'(REFRESH_DIV - 1));
    assign idx_last = (idx == IW'(N_DIGITS - 1));

    // Guard window: the first GUARD_CYC cycles of every slot are dark.
    generate
        if (GUARD_CYC == 0) begin : g_noguard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (cnt < CW'(GUARD_CYC));
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] code, input logic hx);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            4'd10:   s = hx ? 7'b1110111 : 7'b0000001;
            4'd11:   s = hx ? 7'b0011111 : 7'b0000001;
            4'd12:   s = hx ? 7'b1001110 : 7'b0000001;
            4'd13:   s = hx ? 7'b0111101 : 7'b0000001;
            4'd14:   s = hx ? 7'b1001111 : 7'b0000001;
            default: s = hx ? 7'b1000111 : 7'b0000001;
        endcase
        return s;
    endfunction

    // Scan counters and shadow register; loads never perturb the scan.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt   <= '0;
            idx   <= '0;
            sh_dp <= '0;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                sh_dig[i] <= '0;
            end
        end else begin
            cnt <= cnt_last ? '0 : cnt + CW'(1);
            if (cnt_last) begin
                idx <= idx_last ? '0 : idx + IW'(1);
            end
            if (load) begin
                sh_dp <= dp_in;
                for (int i = 0; i < int'(N_DIGITS); i++) begin
                    sh_dig[i] <= data_in[4*i +: 4];
                end
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            all_zero = all_zero & (sh_dig[i] == 4'd0);
            if (i != 0) begin
                supp[i] = all_zero & lz_suppress;
            end
        end
    end

    always_comb begin
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        dig_nxt = '0;
        if (!in_guard && !blank) begin
            dig_nxt[idx] = 1'b1;
            dp_nxt       = sh_dp[idx];
            seg_nxt      = supp[idx] ? 7'b0000000 : decode(sh_dig[idx], hex_mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            seg_out    <= '0;
            dp_out     <= 1'b0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_nxt;
            dp_out     <= dp_nxt;
            dig_en     <= dig_nxt;
            frame_done <= cnt_last & idx_last;
        end
    end

endmodule
